// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane enable helper
// for the on-chip SRAM slave.
package ahb_sram_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_RWAIT,
        ST_RDONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Sizes above a word collapse to all four lanes.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << a;
            HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/sram_be_array.sv
// Word-organised storage with asynchronous read and byte-enabled synchronous
// write; contents are deliberately not reset.
module sram_be_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: zero-wait writes, WAIT_STATES-cycle reads, write-to-read
// forwarding. Define AHB_SRAM_ERR_EN to enable the two-cycle ERROR response.
//
// state    | meaning
// ST_IDLE  | no transfer in data phase
// ST_WDATA | write data phase, commits at the edge ending it
// ST_RWAIT | read stalled, counting wait states
// ST_RDONE | read data valid on HRDATA
// ST_ERR1  | first ERROR cycle (HREADYOUT low)
// ST_ERR2  | second ERROR cycle (HREADYOUT high)
module ahb_lite_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter int          ADDR_W      = 14,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         WA      = ADDR_W - 2;
    localparam int         DEPTH   = 2 ** WA;
    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e        state_q;
    logic          hreadyout_q;
    logic          hresp_q;
    logic [31:0]   rdata_q;
    logic [3:0]    cnt_q;
    logic [WA-1:0] waddr_q;
    logic [3:0]    be_q;

    logic          xfer;
    logic          accept;
    logic          err;
    logic [3:0]    be_in;
    logic [WA-1:0] haddr_word;
    logic          wr_commit;
    logic          fwd_hit;
    logic [31:0]   arr_rdata;
    logic [31:0]   fwd_rdata;

    assign haddr_word = HADDR[ADDR_W-1:2];
    assign xfer       = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign accept     = HSEL && HREADY && xfer && hreadyout_q;
    assign be_in      = byte_en(HSIZE, HADDR[1:0]);

`ifdef AHB_SRAM_ERR_EN
    assign err = (HADDR[31:ADDR_W] != BASE_ADDR[31:ADDR_W])
              || (HSIZE > HSIZE_WORD)
              || ((HSIZE == HSIZE_HALF) && HADDR[0])
              || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
`else
    // Upper address bits are ignored so out-of-range accesses alias.
    logic unused_hi;
    assign unused_hi = ^{HADDR[31:ADDR_W], BASE_ADDR[31:ADDR_W]};
    assign err       = 1'b0;
`endif

    assign wr_commit = (state_q == ST_WDATA);
    assign fwd_hit   = wr_commit && (waddr_q == haddr_word);

    always_comb begin
        fwd_rdata = arr_rdata;
        for (int i = 0; i < 4; i++) begin
            if (fwd_hit && be_q[i]) fwd_rdata[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    sram_be_array #(
        .DEPTH(DEPTH),
        .AW   (WA)
    ) u_mem (
        .clk    (clk),
        .we_i   (wr_commit),
        .be_i   (be_q),
        .waddr_i(waddr_q),
        .wdata_i(HWDATA),
        .raddr_i(haddr_word),
        .rdata_o(arr_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            rdata_q     <= '0;
            cnt_q       <= '0;
            waddr_q     <= '0;
            be_q        <= '0;
        end else if (hreadyout_q) begin
            if (accept) begin
                waddr_q <= haddr_word;
                be_q    <= be_in;
                cnt_q   <= '0;
                if (err) begin
                    state_q     <= ST_ERR1;
                    hreadyout_q <= 1'b0;
                    hresp_q     <= HRESP_ERROR;
                end else if (HWRITE) begin
                    state_q     <= ST_WDATA;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end else begin
                    rdata_q     <= fwd_rdata;
                    state_q     <= (WAIT_STATES == 0) ? ST_RDONE : ST_RWAIT;
                    hreadyout_q <= (WAIT_STATES == 0);
                    hresp_q     <= HRESP_OKAY;
                end
            end else begin
                state_q     <= ST_IDLE;
                hreadyout_q <= 1'b1;
                hresp_q     <= HRESP_OKAY;
            end
        end else begin
            case (state_q)
                ST_RWAIT: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == WS_LAST) begin
                        state_q     <= ST_RDONE;
                        hreadyout_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rdata_q;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: three instances with 1, 0 and 3 read
// wait states, each slave's HREADYOUT looped back as its HREADY.
module tb_ahb_lite_sram_slave;

    logic        clk = 1'b0;
    logic        rst       [3];
    logic        hsel      [3];
    logic [31:0] haddr     [3];
    logic        hwrite    [3];
    logic [2:0]  hsize     [3];
    logic [1:0]  htrans    [3];
    logic [31:0] hwdata    [3];
    logic        hready    [3];
    logic        hreadyout [3];
    logic        hresp     [3];
    logic [31:0] hrdata    [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];
    assign hready[2] = hreadyout[2];

    ahb_lite_sram_slave #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
        .HSIZE(hsize[0]), .HTRANS(htrans[0]), .HWDATA(hwdata[0]), .HREADY(hready[0]),
        .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

    ahb_lite_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
        .HSIZE(hsize[1]), .HTRANS(htrans[1]), .HWDATA(hwdata[1]), .HREADY(hready[1]),
        .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

    ahb_lite_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst[2]), .HSEL(hsel[2]), .HADDR(haddr[2]), .HWRITE(hwrite[2]),
        .HSIZE(hsize[2]), .HTRANS(htrans[2]), .HWDATA(hwdata[2]), .HREADY(hready[2]),
        .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]), .HRDATA(hrdata[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_bus(input string tag, input int k, input logic rdy, input logic resp);
        chk({tag, ".hreadyout"}, 32'(hreadyout[k]), 32'(rdy));
        chk({tag, ".hresp"}, 32'(hresp[k]), 32'(resp));
    endtask

    task automatic addr_ph(input int k, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel[k]   = 1'b1;
        htrans[k] = 2'd2;
        hwrite[k] = wr;
        haddr[k]  = a;
        hsize[k]  = sz;
    endtask

    task automatic idle_ph(input int k);
        hsel[k]   = 1'b0;
        htrans[k] = 2'd0;
        hwrite[k] = 1'b0;
        haddr[k]  = '0;
        hsize[k]  = '0;
    endtask

    task automatic nxt;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0;
            hwdata[k] = '0;
            idle_ph(k);
        end
        nxt; nxt;
        for (int k = 0; k < 3; k++) begin
            chk_bus($sformatf("reset%0d", k), k, 1'b1, 1'b0);
            chk($sformatf("reset%0d.hrdata", k), hrdata[k], 32'h0);
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        nxt;

        // WAIT_STATES=1: word write then back-to-back read, then plain read
        addr_ph(0, 1'b1, 32'h10, 3'd2); nxt;
        hwdata[0] = 32'hDEAD_BEEF; addr_ph(0, 1'b0, 32'h10, 3'd2);
        chk_bus("t1_wr", 0, 1'b1, 1'b0); nxt;
        idle_ph(0); chk_bus("t1_rwait", 0, 1'b0, 1'b0); nxt;
        chk_bus("t1_rdone", 0, 1'b1, 1'b0);
        chk("t1_rdata_fwd", hrdata[0], 32'hDEAD_BEEF);
        addr_ph(0, 1'b0, 32'h10, 3'd2); nxt;
        idle_ph(0); chk_bus("t1_rwait2", 0, 1'b0, 1'b0); nxt;
        chk_bus("t1_rdone2", 0, 1'b1, 1'b0);
        chk("t1_rdata_arr", hrdata[0], 32'hDEAD_BEEF);

        // WAIT_STATES=0: byte write forwarded into immediate read
        addr_ph(1, 1'b1, 32'h10, 3'd2); nxt;
        hwdata[1] = 32'h1122_3344; addr_ph(1, 1'b1, 32'h13, 3'd0); nxt;
        hwdata[1] = 32'hAA00_0000; addr_ph(1, 1'b0, 32'h10, 3'd2); nxt;
        idle_ph(1); chk_bus("t2_rd", 1, 1'b1, 1'b0);
        chk("t2_fwd", hrdata[1], 32'hAA22_3344); nxt;
        addr_ph(1, 1'b0, 32'h10, 3'd2); nxt;
        idle_ph(1); chk("t2_arr", hrdata[1], 32'hAA22_3344); nxt;

        // Halfword at 0x22 over zero, then byte at 0x21
        addr_ph(1, 1'b1, 32'h20, 3'd2); nxt;
        hwdata[1] = 32'h0; addr_ph(1, 1'b1, 32'h22, 3'd1); nxt;
        hwdata[1] = 32'h5566_0000; idle_ph(1); nxt;
        addr_ph(1, 1'b0, 32'h20, 3'd2); nxt;
        idle_ph(1); chk("t3_half", hrdata[1], 32'h5566_0000); nxt;
        addr_ph(1, 1'b1, 32'h21, 3'd0); nxt;
        hwdata[1] = 32'h0000_7700; idle_ph(1); nxt;
        addr_ph(1, 1'b0, 32'h20, 3'd2); nxt;
        idle_ph(1); chk("t3_byte", hrdata[1], 32'h5566_7700); nxt;
        chk("t3_hold", hrdata[1], 32'h5566_7700);

`ifdef AHB_SRAM_ERR_EN
        // Misaligned word read -> two-cycle ERROR, memory untouched
        addr_ph(1, 1'b0, 32'h11, 3'd2); nxt;
        idle_ph(1); chk_bus("e1_err1", 1, 1'b0, 1'b1); nxt;
        chk_bus("e1_err2", 1, 1'b1, 1'b1); nxt;
        chk_bus("e1_idle", 1, 1'b1, 1'b0);
        addr_ph(1, 1'b0, 32'h10, 3'd2); nxt;
        idle_ph(1); chk("e1_mem", hrdata[1], 32'hAA22_3344); nxt;
        // Out-of-range write -> ERROR, read in ERR2 sees prior word 0
        addr_ph(1, 1'b1, 32'h0, 3'd2); nxt;
        hwdata[1] = 32'h0BAD_C0DE; addr_ph(1, 1'b1, 32'h0001_0000, 3'd2); nxt;
        hwdata[1] = 32'hFFFF_FFFF; idle_ph(1); chk_bus("e2_err1", 1, 1'b0, 1'b1); nxt;
        chk_bus("e2_err2", 1, 1'b1, 1'b1); addr_ph(1, 1'b0, 32'h0, 3'd2); nxt;
        idle_ph(1); chk_bus("e2_rd", 1, 1'b1, 1'b0);
        chk("e2_mem", hrdata[1], 32'h0BAD_C0DE); nxt;
`else
        // Out-of-range address aliases; HSIZE>2 acts as an aligned word
        addr_ph(1, 1'b1, 32'h0001_0040, 3'd2); nxt;
        hwdata[1] = 32'h1357_9BDF; idle_ph(1); chk_bus("a1_wr", 1, 1'b1, 1'b0); nxt;
        addr_ph(1, 1'b0, 32'h40, 3'd2); nxt;
        idle_ph(1); chk("a1_alias", hrdata[1], 32'h1357_9BDF); nxt;
        addr_ph(1, 1'b1, 32'h41, 3'd3); nxt;
        hwdata[1] = 32'hFFFF_FFFF; addr_ph(1, 1'b0, 32'h40, 3'd2); nxt;
        idle_ph(1); chk_bus("a2_rd", 1, 1'b1, 1'b0);
        chk("a2_size3", hrdata[1], 32'hFFFF_FFFF); nxt;
`endif

        // WAIT_STATES=3: three stall cycles
        addr_ph(2, 1'b1, 32'h30, 3'd2); nxt;
        hwdata[2] = 32'hCAFE_F00D; addr_ph(2, 1'b0, 32'h30, 3'd2);
        chk_bus("t4_wr", 2, 1'b1, 1'b0); nxt;
        idle_ph(2); chk_bus("t4_w0", 2, 1'b0, 1'b0); nxt;
        chk_bus("t4_w1", 2, 1'b0, 1'b0); nxt;
        chk_bus("t4_w2", 2, 1'b0, 1'b0); nxt;
        chk_bus("t4_done", 2, 1'b1, 1'b0);
        chk("t4_rdata", hrdata[2], 32'hCAFE_F00D);

        // Async reset while in RWAIT
        addr_ph(2, 1'b0, 32'h30, 3'd2); nxt;
        idle_ph(2); chk_bus("t5_rwait", 2, 1'b0, 1'b0);
        #1 rst[2] = 1'b0;
        #1 chk_bus("t5_rst", 2, 1'b1, 1'b0);
        chk("t5_rst.hrdata", hrdata[2], 32'h0);
        nxt; rst[2] = 1'b1; nxt;

        // Async reset during a write data phase: write must not commit
        addr_ph(2, 1'b1, 32'h30, 3'd2); nxt;
        hwdata[2] = 32'h1234_5678; idle_ph(2); chk_bus("t6_wdata", 2, 1'b1, 1'b0);
        #1 rst[2] = 1'b0;
        nxt; rst[2] = 1'b1; nxt;
        addr_ph(2, 1'b0, 32'h30, 3'd2); nxt;
        idle_ph(2); nxt; nxt; nxt;
        chk_bus("t6_rd", 2, 1'b1, 1'b0);
        chk("t6_mem", hrdata[2], 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ahb_lite_sram_slave.md
Name: ahb_lite_sram_slave

Overview:
- AHB-Lite3 slave that sits directly downstream of the core's dBusAhbLite3/iBusAhbLite3 master ports and serves them from on-chip word-organised SRAM.
- Supports byte, halfword and word transfers with a configurable number of read wait states and zero-wait writes.
- Forwards a write that is still committing into a read issued back-to-back.
- Optionally returns the AHB two-cycle ERROR response for out-of-range or misaligned accesses.

Parameters:
- ADDR_W, 14: byte-address bits decoded inside the slave; memory depth is 2**(ADDR_W-2) words.
- BASE_ADDR, 32'h0000_0000: region base; compared against HADDR[31:ADDR_W].
- WAIT_STATES, 1: HREADYOUT-low cycles inserted in every read data phase (0..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  address-phase byte address.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready; address phase is sampled only when 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data, valid when HREADYOUT=1 in a read data phase.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wait counter=0, pending write cleared. Memory contents are not reset.
- Accept condition: HSEL & HREADY & HTRANS[1]. The slave registers addr, size and write in that case. IDLE/BUSY or unselected gets a zero-wait OKAY.
- FSM states:
  - IDLE: no transfer in data phase.
  - WDATA: write data phase, HREADYOUT=1. At the edge ending it, HWDATA byte lanes are written to word addr[ADDR_W-1:2].
  - RWAIT: HREADYOUT=0 while counter < WAIT_STATES, counter increments each cycle.
  - RDONE: HREADYOUT=1, HRDATA valid.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Transitions:
  - From any state whose cycle has HREADYOUT=1, an accepted transfer goes to WDATA, RWAIT, RDONE or ERR1. Reads go to RDONE if WAIT_STATES=0, else RWAIT.
  - Otherwise the FSM goes to IDLE.
  - RWAIT goes to RDONE when the counter reaches WAIT_STATES-1.
  - ERR1 always goes to ERR2.
- Byte lanes: byte uses lane addr[1:0]; half uses lanes {addr[1],0} and {addr[1],1}; word uses all four. HWDATA is lane-aligned (no shifting).
- Read data register:
  - Loaded from the array at the accept edge. Full 32-bit word returned regardless of HSIZE.
  - Forwarding: if a WDATA commit occurs on the same edge to the same word, the committing byte lanes take HWDATA, the rest take the array.
  - Held until the next read accept.
- Back-to-back write then read to the same word returns the new data with no extra stall.
- Errors (macro on): HADDR[31:ADDR_W] != BASE_ADDR[31:ADDR_W], HSIZE>2, half with addr[0]=1, or word with addr[1:0]!=0. No memory write occurs.
- A transfer presented during ERR2 (HREADY=1) is accepted normally. A transfer presented during ERR1 is ignored.
- Async reset mid-transfer: immediate return to reset values; a write in WDATA is not committed.

Optional Feature:
- AHB_SRAM_ERR_EN defined: error detection and ERR1/ERR2 as above.
- AHB_SRAM_ERR_EN undefined:
  - HRESP tied 0, ERR states absent.
  - Out-of-range addresses alias into memory via addr[ADDR_W-1:0].
  - Misaligned accesses use the lanes the HSIZE rule yields.
  - HSIZE>2 is treated as word with addr[1:0] forced to 0.

Decomposition:
- ahb_sram_pkg holds: HTRANS/HSIZE/HRESP localparams, state enum typedef, and a byte-enable function (size, addr[1:0]) -> 4-bit mask.
- One sub-module, sram_be_array: parameterised depth, asynchronous read, byte-enable synchronous write, no reset.

Test Plan:
- WAIT_STATES=1, write word 0xDEADBEEF to 0x10, then NONSEQ read 0x10 -> write OKAY zero-wait; read has one HREADYOUT=0 cycle, then HRDATA=0xDEADBEEF.
- Byte write 0xAA at 0x13 over word 0x11223344, then immediate read 0x10 with WAIT_STATES=0 -> HRDATA=0xAA223344 in the next cycle (forwarding path).
- Halfword write 0x5566 at 0x22 (HWDATA 0x55660000) over 0 -> read 0x20 returns 0x55660000.
- ERR_EN: word read at 0x11 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1); memory unchanged; an IDLE following it gets OKAY.
- ERR_EN: write to 0x0001_0000 with ADDR_W=14 -> two-cycle ERROR; a subsequent read of 0x0 returns its prior value.
- Assert rst low during RWAIT with WAIT_STATES=3 -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; a write stalled in WDATA at reset leaves memory unchanged.
